// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge-detection datapath.
// Both the horizontal and vertical gradient blocks import this package.
package sobel_pkg;

    localparam int unsigned PIXEL_W   = 8;
    localparam int unsigned GX_W      = 11;
    // Each column sum a + 2*b + c tops out at 4*255 = 1020.
    localparam int unsigned COL_SUM_W = 10;

    typedef logic [PIXEL_W-1:0]   pixel_t;
    typedef pixel_t [0:8]         window_t;
    typedef logic [COL_SUM_W-1:0] col_sum_t;
    typedef logic [GX_W-1:0]      gx_t;

    // Row-major 3x3 window: left column is 0,3,6 and right column is 2,5,8.
    localparam int unsigned LEFT_TOP  = 0;
    localparam int unsigned LEFT_MID  = 3;
    localparam int unsigned LEFT_BOT  = 6;
    localparam int unsigned RIGHT_TOP = 2;
    localparam int unsigned RIGHT_MID = 5;
    localparam int unsigned RIGHT_BOT = 8;

endpackage

// File: rtl/horizontal_gradient_if.sv
// Window-in / gradient-out bundle between the window buffer and the gradient block.
interface horizontal_gradient_if;
    import sobel_pkg::*;

    window_t windowBuffer;
    logic    start_calculations;
    gx_t     gx;
    logic    gx_negative;
    logic    gx_valid;

    modport master (
        output windowBuffer,
        output start_calculations,
        input  gx,
        input  gx_negative,
        input  gx_valid
    );

    modport slave (
        input  windowBuffer,
        input  start_calculations,
        output gx,
        output gx_negative,
        output gx_valid
    );

endinterface

// File: rtl/sobel_column_sum.sv
// Weighted sum of one kernel column: top + 2*mid + bot, unsigned.
module sobel_column_sum
    import sobel_pkg::*;
(
    input  pixel_t   top,
    input  pixel_t   mid,
    input  pixel_t   bot,
    output col_sum_t sum
);

    assign sum = COL_SUM_W'(top) + COL_SUM_W'({mid, 1'b0}) + COL_SUM_W'(bot);

endmodule

// File: rtl/horizontal_gradient.sv
// Sobel |Gx| of one 3x3 window: right column sum minus left column sum,
// reported as a registered magnitude plus sign with a one-cycle valid pulse.
module horizontal_gradient
    import sobel_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    horizontal_gradient_if.slave  bus
);

    col_sum_t left_sum;
    col_sum_t right_sum;
    logic     left_brighter;
    gx_t      magnitude;

    sobel_column_sum u_left_col (
        .top (bus.windowBuffer[LEFT_TOP]),
        .mid (bus.windowBuffer[LEFT_MID]),
        .bot (bus.windowBuffer[LEFT_BOT]),
        .sum (left_sum)
    );

    sobel_column_sum u_right_col (
        .top (bus.windowBuffer[RIGHT_TOP]),
        .mid (bus.windowBuffer[RIGHT_MID]),
        .bot (bus.windowBuffer[RIGHT_BOT]),
        .sum (right_sum)
    );

    // Subtracting the smaller sum from the larger yields |Gx| directly and
    // keeps Gx == 0 from ever being flagged negative.
    always_comb begin
        left_brighter = (left_sum > right_sum);
        if (left_brighter) begin
            magnitude = GX_W'(left_sum) - GX_W'(right_sum);
        end else begin
            magnitude = GX_W'(right_sum) - GX_W'(left_sum);
        end
    end

    // NOTE: non-blocking assignments for registered state; reset is synchronous
    // and wins over start_calculations on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gx          <= '0;
            bus.gx_negative <= 1'b0;
            bus.gx_valid    <= 1'b0;
        end else if (bus.start_calculations) begin
            bus.gx          <= magnitude;
            bus.gx_negative <= left_brighter;
            bus.gx_valid    <= 1'b1;
        end else begin
            bus.gx_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_horizontal_gradient.sv
// Directed, table-driven bench for horizontal_gradient with hand-computed |Gx|.
module tb_horizontal_gradient;
    import sobel_pkg::*;

    logic clk;
    logic rst;

    horizontal_gradient_if bus ();

    horizontal_gradient dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string   name;
        logic    rst;
        logic    start;
        window_t win;
        int      exp_gx;
        logic    exp_neg;
        logic    exp_valid;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    function automatic window_t mk_win(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
        window_t w;
        w[0] = pixel_t'(p0); w[1] = pixel_t'(p1); w[2] = pixel_t'(p2);
        w[3] = pixel_t'(p3); w[4] = pixel_t'(p4); w[5] = pixel_t'(p5);
        w[6] = pixel_t'(p6); w[7] = pixel_t'(p7); w[8] = pixel_t'(p8);
        return w;
    endfunction

    function automatic vec_t mk_vec(input string n, input logic r, input logic s,
                                    input window_t w, input int g, input logic ng,
                                    input logic v);
        vec_t t;
        t.name = n; t.rst = r; t.start = s; t.win = w;
        t.exp_gx = g; t.exp_neg = ng; t.exp_valid = v;
        return t;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic r, input logic s, input window_t w);
        @(negedge clk);
        rst = r;
        bus.start_calculations = s;
        bus.windowBuffer = w;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input int g, input logic ng, input logic v);
        check({name, ".gx"},          int'(bus.gx),          g);
        check({name, ".gx_negative"}, int'(bus.gx_negative), int'(ng));
        check({name, ".gx_valid"},    int'(bus.gx_valid),    int'(v));
    endtask

    initial begin
        window_t w_zero, w_555, w_left, w_right, w_mid_only, w_equal;
        window_t w_neg7, w_lmid, w_rmid;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start_calculations = 1'b0;
        bus.windowBuffer = '0;

        w_zero     = mk_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
        w_555      = mk_win(50, 255, 250, 100, 0, 200, 100, 255, 255);
        w_left     = mk_win(255, 0, 0, 255, 0, 0, 255, 0, 0);
        w_right    = mk_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        w_mid_only = mk_win(0, 200, 0, 0, 200, 0, 0, 200, 0);
        w_equal    = mk_win(5, 9, 5, 5, 9, 5, 5, 9, 5);
        w_neg7     = mk_win(10, 0, 0, 0, 0, 0, 0, 0, 3);
        w_lmid     = mk_win(0, 0, 0, 1, 0, 0, 0, 0, 0);
        w_rmid     = mk_win(0, 0, 0, 0, 0, 7, 0, 0, 0);

        vecs.push_back(mk_vec("rst0",       1, 1, w_555,      0,    0, 0));
        vecs.push_back(mk_vec("rst1",       1, 1, w_555,      0,    0, 0));
        vecs.push_back(mk_vec("zero",       0, 1, w_zero,     0,    0, 1));
        vecs.push_back(mk_vec("w555",       0, 1, w_555,      555,  0, 1));
        vecs.push_back(mk_vec("hold0",      0, 0, w_left,     555,  0, 0));
        vecs.push_back(mk_vec("hold1",      0, 0, w_right,    555,  0, 0));
        vecs.push_back(mk_vec("hold2",      0, 0, w_zero,     555,  0, 0));
        vecs.push_back(mk_vec("left_max",   0, 1, w_left,     1020, 1, 1));
        vecs.push_back(mk_vec("right_max",  0, 1, w_right,    1020, 0, 1));
        vecs.push_back(mk_vec("idle",       0, 0, w_555,      1020, 0, 0));
        vecs.push_back(mk_vec("b2b0",       0, 1, w_555,      555,  0, 1));
        vecs.push_back(mk_vec("b2b1",       0, 1, w_left,     1020, 1, 1));
        vecs.push_back(mk_vec("b2b2",       0, 1, w_right,    1020, 0, 1));
        vecs.push_back(mk_vec("mid_rst",    1, 1, w_left,     0,    0, 0));
        vecs.push_back(mk_vec("post_rst",   0, 0, w_left,     0,    0, 0));
        vecs.push_back(mk_vec("centre_col", 0, 1, w_mid_only, 0,    0, 1));
        vecs.push_back(mk_vec("neg7",       0, 1, w_neg7,     7,    1, 1));
        vecs.push_back(mk_vec("equal_cols", 0, 1, w_equal,    0,    0, 1));
        vecs.push_back(mk_vec("left_mid",   0, 1, w_lmid,     2,    1, 1));
        vecs.push_back(mk_vec("right_mid",  0, 1, w_rmid,     14,   0, 1));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].start, vecs[i].win);
            check_outputs(vecs[i].name, vecs[i].exp_gx, vecs[i].exp_neg, vecs[i].exp_valid);
        end

        // Single start pulse: valid for exactly one cycle, value then held.
        apply(0, 0, w_zero);
        check_outputs("pulse_pre", 14, 0, 0);
        apply(0, 1, w_neg7);
        check_outputs("pulse_hi", 7, 1, 1);
        apply(0, 0, w_555);
        check_outputs("pulse_lo", 7, 1, 0);
        apply(0, 0, w_right);
        check_outputs("pulse_lo2", 7, 1, 0);

        // Reset arriving directly after a negative result clears the sign too.
        apply(0, 1, w_left);
        check_outputs("pre_clear", 1020, 1, 1);
        apply(1, 0, w_left);
        check_outputs("clear", 0, 0, 0);
        apply(0, 1, w_555);
        check_outputs("recover", 555, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
